// File: rtl/instruction_asm_pkg.sv
// Shared types and constants for the instruction assembler.
// Frame length depends on ASM_CHECKSUM_EN (adds a trailing XOR checksum byte).
package instruction_asm_pkg;

    localparam int unsigned FIELD_W     = 8;
    localparam int unsigned FIELD_BYTES = 6;
`ifdef ASM_CHECKSUM_EN
    localparam int unsigned FRAME_BYTES = 7;
`else
    localparam int unsigned FRAME_BYTES = 6;
`endif
    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 12;

    typedef logic [FIELD_W-1:0]     field_t;
    // Index 0 is opcode, index 5 is op2l.
    typedef field_t [FIELD_BYTES-1:0] frame_t;

    typedef enum logic [1:0] {IDLE, COLLECT, EMIT, FULL} asm_state_e;

`ifdef ASM_CHECKSUM_EN
    function automatic field_t frame_xor(input frame_t f);
        field_t x;
        x = '0;
        for (int i = 0; i < FIELD_BYTES; i++) begin
            x ^= f[i];
        end
        return x;
    endfunction
`endif

endpackage

// File: rtl/instruction_assembler_if.sv
// Byte-in / frame-out bus of the instruction assembler.
interface instruction_assembler_if;
    import instruction_asm_pkg::*;

    field_t             rx_data;
    logic               rx_valid;
    field_t             opcode;
    field_t             sel;
    field_t             op1h;
    field_t             op1l;
    field_t             op2h;
    field_t             op2l;
    logic               load;
    logic               busy;
    logic               done;
    logic               err;
    logic [CNT_W-1:0]   instr_cnt;

    modport master (
        output rx_data, rx_valid,
        input  opcode, sel, op1h, op1l, op2h, op2l, load, busy, done, err, instr_cnt
    );

    modport slave (
        input  rx_data, rx_valid,
        output opcode, sel, op1h, op1l, op2h, op2l, load, busy, done, err, instr_cnt
    );

endinterface

// File: rtl/byte_timeout.sv
// Inter-byte idle counter: expired fires on the TIMEOUT_CYCLES-th consecutive
// enabled clock without a restart.
module byte_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 9600
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic restart,
    output logic expired
);

    // Wide enough to hold TIMEOUT_CYCLES itself, so it never wraps.
    localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: cleared on restart or when not collecting.
    always_comb begin
        cnt_d = cnt_q;
        if (!enable || restart) begin
            cnt_d = '0;
        end else if (cnt_q != W'(TIMEOUT_CYCLES)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expired = enable && !restart && (cnt_q >= W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/instruction_assembler.sv
// Collects UART bytes into instruction frames and presents them with a load strobe.
// Optional feature macro: ASM_CHECKSUM_EN (7th byte = XOR of the six field bytes).
module instruction_assembler
    import instruction_asm_pkg::*;
#(
    parameter int unsigned NUMBER_OF_INSTRUCTIONS = 4,
    parameter int unsigned TIMEOUT_CYCLES         = 9600
) (
    input logic                    clk,
    input logic                    rst,
    instruction_assembler_if.slave bus
);

    asm_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    frame_t           shadow_q, shadow_d;
    frame_t           fields_q, fields_d;
    logic             load_q, load_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             expired;

    byte_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .enable (state_q == COLLECT),
        .restart(bus.rx_valid),
        .expired(expired)
    );

    assign cnt_inc = cnt_q + CNT_W'(1);

    // Next-state, shadow-buffer capture and strobe generation.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        fields_d = fields_q;
        load_d   = 1'b0;
        err_d    = 1'b0;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.rx_valid) begin
                    shadow_d[0] = bus.rx_data;
                    idx_d       = IDX_W'(1);
                    state_d     = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.rx_valid) begin
                    if (idx_q == IDX_W'(FRAME_BYTES - 1)) begin
                        idx_d = '0;
`ifdef ASM_CHECKSUM_EN
                        if (bus.rx_data == frame_xor(shadow_q)) begin
                            fields_d = shadow_q;
                            load_d   = 1'b1;
                            state_d  = EMIT;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
`else
                        fields_d                = shadow_q;
                        fields_d[FIELD_BYTES-1] = bus.rx_data;
                        load_d                  = 1'b1;
                        state_d                 = EMIT;
`endif
                    end else begin
                        for (int i = 0; i < FIELD_BYTES; i++) begin
                            if (idx_q == IDX_W'(i)) shadow_d[i] = bus.rx_data;
                        end
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (expired) begin
                    idx_d   = '0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            EMIT: begin
                cnt_d = cnt_inc;
                if (cnt_inc == CNT_W'(NUMBER_OF_INSTRUCTIONS)) begin
                    state_d = FULL;
                end else if (bus.rx_valid) begin
                    // A byte arriving while the strobe is out opens the next frame.
                    shadow_d[0] = bus.rx_data;
                    idx_d       = IDX_W'(1);
                    state_d     = COLLECT;
                end else begin
                    state_d = IDLE;
                end
            end
            FULL: begin
                state_d = FULL;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            shadow_q <= '0;
            fields_q <= '0;
            load_q   <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            fields_q <= fields_d;
            load_q   <= load_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.opcode    = fields_q[0];
    assign bus.sel       = fields_q[1];
    assign bus.op1h      = fields_q[2];
    assign bus.op1l      = fields_q[3];
    assign bus.op2h      = fields_q[4];
    assign bus.op2l      = fields_q[5];
    assign bus.load      = load_q;
    assign bus.err       = err_q;
    assign bus.busy      = (state_q == COLLECT);
    assign bus.done      = (state_q == FULL);
    assign bus.instr_cnt = cnt_q;

endmodule
